// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue/writeback stage around a combinational 16-bit ALU.
// Accepts one instruction per two cycles over valid/ready, reads operands from
// an internal register file (r0 hardwired to zero), drives registered operands
// into the ALU, then captures the result and flags and writes the result back.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   instr_valid/ready      instruction handshake (ready is combinational)
//   instr_op/rd/rs1/rs2    opcode, destination and source register indices
//   instr_use_imm/imm      select immediate as operand B
//   alu_a/alu_b/alu_op     registered ALU operands and opcode
//   alu_result/zero/carry/overflow   ALU outputs sampled at the end of EXEC
//   flags                  status register {overflow, carry, zero}
//   wb_valid/wb_rd/wb_data one-cycle writeback strobe with held rd/data
//   dbg_addr/dbg_data      combinational register file read port
module alu_issue_stage #(
   parameter int unsigned NREGS = 8,
   parameter int unsigned AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [3:0]    instr_op,
   input  logic [AW-1:0] instr_rd,
   input  logic [AW-1:0] instr_rs1,
   input  logic [AW-1:0] instr_rs2,
   input  logic          instr_use_imm,
   input  logic [15:0]   instr_imm,
   output logic [15:0]   alu_a,
   output logic [15:0]   alu_b,
   output logic [3:0]    alu_op,
   input  logic [15:0]   alu_result,
   input  logic          alu_zero,
   input  logic          alu_carry,
   input  logic          alu_overflow,
   output logic [2:0]    flags,
   output logic          wb_valid,
   output logic [AW-1:0] wb_rd,
   output logic [15:0]   wb_data,
   input  logic [AW-1:0] dbg_addr,
   output logic [15:0]   dbg_data
);

   localparam int unsigned DW = 16;

   typedef enum logic {IDLE, EXEC} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   rf_q [NREGS];
   logic [DW-1:0]   alu_a_q, alu_a_d;
   logic [DW-1:0]   alu_b_q, alu_b_d;
   logic [3:0]      alu_op_q, alu_op_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [2:0]      flags_q, flags_d;
   logic            wb_valid_q, wb_valid_d;
   logic [AW-1:0]   wb_rd_q, wb_rd_d;
   logic [DW-1:0]   wb_data_q, wb_data_d;
   logic            rf_we;

   // Register file read with r0 forced to zero on every read path
   function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] idx);
      if (idx == '0) return '0;
      return rf_q[idx];
   endfunction

   // Next-state and datapath control
   always_comb begin
      state_d    = state_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      rd_d       = rd_q;
      flags_d    = flags_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      rf_we      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (instr_valid) begin
               alu_a_d  = rf_read(instr_rs1);
               alu_b_d  = instr_use_imm ? instr_imm : rf_read(instr_rs2);
               alu_op_d = instr_op;
               rd_d     = instr_rd;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            // ALU output settles during this cycle; capture on the closing edge
            flags_d    = {alu_overflow, alu_carry, alu_zero};
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = alu_result;
            rf_we      = (rd_q != '0);
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pipeline and register file storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_op_q   <= '0;
         rd_q       <= '0;
         flags_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_op_q   <= alu_op_d;
         rd_q       <= rd_d;
         flags_q    <= flags_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         if (rf_we) rf_q[rd_q] <= alu_result;
      end
   end

   assign instr_ready = (state_q == IDLE);
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign flags       = flags_q;
   assign wb_valid    = wb_valid_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign dbg_data    = rf_read(dbg_addr);

endmodule
